lcd_digit_scanner: RTL and testbench
====================================

Name: lcd_digit_scanner

Overview:
Upstream feeder for the PWM/AC-drive stage of the digital display. It holds a double-buffered multi-digit hex display, decodes each digit to 7-segment plus decimal point, and time-multiplexes the digits with a one-hot digit select. It produces the positive-phase segment pattern and its complement, which the downstream PWM stage alternates to drive the display. Shadow-to-active commit is frame-aligned so the display never shows a partial update.

Parameters:
DIGITS, 4, number of digits (2..8); digit 0 = least significant.
SCAN_CNT, 50000, clk cycles per digit slot (1 kHz/digit at 50 MHz); must be > BLANK_CNT.
BLANK_CNT, 500, dead-time cycles at the start of each slot, all segments and digits off.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-low reset.
wr_en  in  1  write strobe into shadow buffer.
wr_addr  in  3  digit index; writes with wr_addr >= DIGITS are ignored.
wr_data  in  5  {dp, hex[3:0]}.
commit  in  1  single-cycle request to copy shadow to active at next frame boundary.
seg_pos  out  8  {dp,g,f,e,d,c,b,a}, active-high.
seg_neg  out  8  complement phase, ~seg_pos, except during blanking.
digit_sel  out  DIGITS  one-hot active-high digit enable.
frame_start  out  1  one-cycle pulse at the start of digit 0's slot.
commit_done  out  1  one-cycle pulse when the active buffer was updated.

Behaviour:
- One clock domain: clk. Reset: synchronous, active-low, port rst. All state changes on posedge clk only.
- Reset (rst=0 at posedge): slot counter cnt=0, digit index idx=0, shadow and active buffers all 0, pending=0. Outputs: seg_pos=0, seg_neg=0, digit_sel=0, frame_start=0, commit_done=0. Reset mid-frame aborts the slot immediately; a pending commit is discarded.
- Scan counter: cnt counts 0..SCAN_CNT-1, then wraps to 0. On the wrap, idx increments; idx wraps from DIGITS-1 to 0.
- Frame boundary: the cycle in which cnt==0 and idx==0.
- Outputs are registered and reflect the (cnt, idx) state of the previous cycle (latency 1). For a state with cnt < BLANK_CNT: seg_pos=0, seg_neg=0, digit_sel=0. Otherwise: seg_pos=dec(active[idx]), seg_neg=~seg_pos, digit_sel=1<<idx.
- frame_start is registered from the frame boundary, so it is high during the first output cycle of digit 0's slot. This includes the first slot after reset release.
- Decode a..g, hex 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. The dp bit maps to bit7.
- Shadow writes: when wr_en=1 and wr_addr < DIGITS, shadow[wr_addr] <= wr_data. Writes never affect the active buffer directly.
- Commit: commit=1 sets pending. On a frame boundary with (pending | commit): active <= shadow (pre-write values), pending <= 0, commit_done=1 the next cycle.
- Simultaneous events:
  - A write on the copy cycle lands in shadow only; it is not copied until the next commit.
  - commit on a frame boundary takes effect that same boundary.
  - Repeated commits before the boundary merge into one copy and one commit_done.

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN.
- Defined: a digit i (i >= 1) whose active hex value is 0 and whose dp bit is 0 shows seg_pos=0 when every digit above i is also blank-eligible. digit_sel still asserts, and seg_neg=~seg_pos=FF. Digit 0 is never blanked.
- Undefined: every digit decodes normally; zeros show 3F.

Test Plan (DIGITS=4, SCAN_CNT=8, BLANK_CNT=2):
1. Reset, release, no writes -> digit_sel sequence 0,0,1 x6, 0,0,2 x6, 0,0,4 x6, 0,0,8 x6 repeating. seg_pos=3F while selected, seg_neg=C0. frame_start every 32 cycles.
2. Write addr0=5, addr1=0x1A (dp+A), addr3=F, then commit mid-frame -> display unchanged until the next frame boundary. Then commit_done pulses once and slots show 6D, F7, 3F, 71.
3. Write addr2=7 in the copy cycle of a commit -> digit 2 still shows the old value. A second commit makes it 07 from the following frame.
4. wr_addr=5 with wr_data=8 -> no buffer change. Three commit pulses within one frame -> exactly one commit_done.
5. Assert rst for 1 cycle mid-slot of digit 2 with a commit pending -> outputs 0 the next cycle. Scan restarts at digit 0, buffers are 0, and no commit_done occurs.
6. LEADING_ZERO_BLANK_EN defined, active = {3:0, 2:0, 1:4, 0:0} -> digits 3 and 2 seg_pos=00, digit 1 shows 66, digit 0 shows 3F. Without the macro, digits 3 and 2 show 3F.

Source files
------------

// File: rtl/lcd_digit_scanner.sv
// Double-buffered hex display scanner: 7-segment decode, one-hot digit scan, frame-aligned commit.
// Optional macro LEADING_ZERO_BLANK_EN suppresses segments of leading zero digits above digit 0.
module lcd_digit_scanner #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned SCAN_CNT  = 50000,
   parameter int unsigned BLANK_CNT = 500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [2:0]        wr_addr,
   input  logic [4:0]        wr_data,
   input  logic              commit,
   output logic [7:0]        seg_pos,
   output logic [7:0]        seg_neg,
   output logic [DIGITS-1:0] digit_sel,
   output logic              frame_start,
   output logic              commit_done
);
   localparam int unsigned CW = $clog2(SCAN_CNT);
   localparam int unsigned IW = $clog2(DIGITS);

   logic [CW-1:0]            cnt_q, cnt_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [DIGITS-1:0][4:0]   shadow_q, shadow_d;
   logic [DIGITS-1:0][4:0]   active_q, active_d;
   logic                     pending_q, pending_d;
   logic [7:0]               seg_pos_q, seg_pos_d;
   logic [7:0]               seg_neg_q, seg_neg_d;
   logic [DIGITS-1:0]        digit_sel_q, digit_sel_d;
   logic                     frame_start_q, frame_start_d;
   logic                     commit_done_q, commit_done_d;
   logic                     boundary;
   logic [4:0]               cur;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      case (hex)
         4'h0:    return 7'h3F;
         4'h1:    return 7'h06;
         4'h2:    return 7'h5B;
         4'h3:    return 7'h4F;
         4'h4:    return 7'h66;
         4'h5:    return 7'h6D;
         4'h6:    return 7'h7D;
         4'h7:    return 7'h07;
         4'h8:    return 7'h7F;
         4'h9:    return 7'h6F;
         4'hA:    return 7'h77;
         4'hB:    return 7'h7C;
         4'hC:    return 7'h39;
         4'hD:    return 7'h5E;
         4'hE:    return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   // lz_blank[i]: digit i and every digit above it are zero without dp; digit 0 never blanks.
   logic [DIGITS-1:0] lz_blank;
   always_comb begin
      lz_blank = '0;
      lz_blank[DIGITS-1] = (active_q[DIGITS-1] == 5'd0);
      for (int i = DIGITS - 2; i >= 1; i--) begin
         lz_blank[i] = lz_blank[i+1] && (active_q[i] == 5'd0);
      end
   end
`endif

   assign boundary = (cnt_q == '0) && (idx_q == '0);
   assign cur      = active_q[idx_q];

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      if (cnt_q == CW'(SCAN_CNT - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end

      shadow_d = shadow_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (wr_en && (wr_addr == 3'(i))) shadow_d[i] = wr_data;
      end

      // Copy uses pre-write shadow so a same-cycle write waits for the next commit.
      active_d      = active_q;
      pending_d     = pending_q | commit;
      commit_done_d = 1'b0;
      if (boundary && (pending_q || commit)) begin
         active_d      = shadow_q;
         pending_d     = 1'b0;
         commit_done_d = 1'b1;
      end

      frame_start_d = boundary;
      seg_pos_d     = '0;
      seg_neg_d     = '0;
      digit_sel_d   = '0;
      if (cnt_q >= CW'(BLANK_CNT)) begin
         seg_pos_d = {cur[4], hex_to_seg(cur[3:0])};
`ifdef LEADING_ZERO_BLANK_EN
         if (lz_blank[idx_q]) seg_pos_d = '0;
`endif
         seg_neg_d          = ~seg_pos_d;
         digit_sel_d[idx_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         shadow_q      <= '0;
         active_q      <= '0;
         pending_q     <= 1'b0;
         seg_pos_q     <= '0;
         seg_neg_q     <= '0;
         digit_sel_q   <= '0;
         frame_start_q <= 1'b0;
         commit_done_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         seg_pos_q     <= seg_pos_d;
         seg_neg_q     <= seg_neg_d;
         digit_sel_q   <= digit_sel_d;
         frame_start_q <= frame_start_d;
         commit_done_q <= commit_done_d;
      end
   end

   assign seg_pos     = seg_pos_q;
   assign seg_neg     = seg_neg_q;
   assign digit_sel   = digit_sel_q;
   assign frame_start = frame_start_q;
   assign commit_done = commit_done_q;

endmodule

// File: tb/tb_lcd_digit_scanner.sv
// Directed bench for lcd_digit_scanner with DIGITS=4, SCAN_CNT=8, BLANK_CNT=2 (32-cycle frame).
// Outputs are packed as {digit_sel, seg_pos, seg_neg, frame_start, commit_done}.
module tb_lcd_digit_scanner;
   localparam int unsigned DIGITS    = 4;
   localparam int unsigned SCAN_CNT  = 8;
   localparam int unsigned BLANK_CNT = 2;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [7:0] ZB = 8'h00;
`else
   localparam logic [7:0] ZB = 8'h3F;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wr_en = 1'b0;
   logic [2:0]        wr_addr = '0;
   logic [4:0]        wr_data = '0;
   logic              commit = 1'b0;
   logic [7:0]        seg_pos;
   logic [7:0]        seg_neg;
   logic [DIGITS-1:0] digit_sel;
   logic              frame_start;
   logic              commit_done;

   logic [21:0] obs;
   logic [21:0] exp_v;
   int          checks   = 0;
   int          failures = 0;
   int          t        = 0;

   assign obs = {digit_sel, seg_pos, seg_neg, frame_start, commit_done};

   always #5 clk = ~clk;

   lcd_digit_scanner #(
      .DIGITS    (DIGITS),
      .SCAN_CNT  (SCAN_CNT),
      .BLANK_CNT (BLANK_CNT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .commit      (commit),
      .seg_pos     (seg_pos),
      .seg_neg     (seg_neg),
      .digit_sel   (digit_sel),
      .frame_start (frame_start),
      .commit_done (commit_done)
   );

   // After step(), outputs reflect scan state number t (t=0 is the first state after release).
   task automatic step();
      @(posedge clk);
      #1;
      t++;
   endtask

   // segs holds the expected seg_pos per digit as {d3, d2, d1, d0}.
   function automatic logic [21:0] exp_out(input int tt, input logic [31:0] segs, input int cd_t);
      int         ix;
      logic       on;
      logic [7:0] pos;
      ix  = (tt / 8) % 4;
      on  = (tt % 8) >= 2;
      pos = on ? segs[8*ix +: 8] : 8'h00;
      return {on ? (4'b0001 << ix) : 4'h0, pos, on ? ~pos : 8'h00,
              (tt % 32) == 0, tt == cd_t};
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (obs !== 22'h0) begin
            failures++;
            $display("FAIL reset k=%0d got=%h exp=%h", k, obs, 22'h0);
         end
      end
      rst = 1'b1;
      t   = -1;
   endtask

   task automatic test_idle_scan();
      for (int k = 0; k < 64; k++) begin
         step();
         exp_v = exp_out(t, {ZB, ZB, ZB, 8'h3F}, -1);
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL idle_scan t=%0d got=%h exp=%h", t, obs, exp_v);
         end
      end
   endtask

   task automatic test_commit_deferred();
      for (int k = 0; k < 64; k++) begin
         wr_en  = 1'b0;
         commit = 1'b0;
         case (t + 1)
            64: begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h05; end
            65: begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = 5'h1A; end
            66: begin wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'h0F; end
            70: commit = 1'b1;
            default: ;
         endcase
         step();
         exp_v = (t < 96) ? exp_out(t, {ZB, ZB, ZB, 8'h3F}, -1)
                          : exp_out(t, {8'h71, 8'h3F, 8'hF7, 8'h6D}, 96);
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL commit_deferred t=%0d got=%h exp=%h", t, obs, exp_v);
         end
      end
      wr_en  = 1'b0;
      commit = 1'b0;
   endtask

   task automatic test_write_on_copy();
      for (int k = 0; k < 64; k++) begin
         wr_en  = 1'b0;
         commit = 1'b0;
         case (t + 1)
            128: begin commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'h07; end
            140: commit = 1'b1;
            default: ;
         endcase
         step();
         exp_v = (t < 160) ? exp_out(t, {8'h71, 8'h3F, 8'hF7, 8'h6D}, 128)
                           : exp_out(t, {8'h71, 8'h07, 8'hF7, 8'h6D}, 160);
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL write_on_copy t=%0d got=%h exp=%h", t, obs, exp_v);
         end
      end
      wr_en  = 1'b0;
      commit = 1'b0;
   endtask

   task automatic test_ignored_addr_merge();
      for (int k = 0; k < 64; k++) begin
         wr_en  = 1'b0;
         commit = 1'b0;
         case (t + 1)
            195: begin wr_en = 1'b1; wr_addr = 3'd5; wr_data = 5'h08; end
            196: begin wr_en = 1'b1; wr_addr = 3'd4; wr_data = 5'h08; end
            200, 205, 210: commit = 1'b1;
            default: ;
         endcase
         step();
         exp_v = (t < 224) ? exp_out(t, {8'h71, 8'h07, 8'hF7, 8'h6D}, -1)
                           : exp_out(t, {8'h71, 8'h07, 8'hF7, 8'h6D}, 224);
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL ignored_addr_merge t=%0d got=%h exp=%h", t, obs, exp_v);
         end
      end
      wr_en  = 1'b0;
      commit = 1'b0;
   endtask

   task automatic test_reset_mid_slot();
      // Run into digit 2's slot (states 272..279) with a commit pending.
      while (t < 274) begin
         commit = ((t + 1) == 260);
         step();
         exp_v = exp_out(t, {8'h71, 8'h07, 8'hF7, 8'h6D}, -1);
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_mid_pre t=%0d got=%h exp=%h", t, obs, exp_v);
         end
      end
      commit = 1'b0;
      rst    = 1'b0;
      step();
      checks++;
      if (obs !== 22'h0) begin
         failures++;
         $display("FAIL reset_mid_out got=%h exp=%h", obs, 22'h0);
      end
      rst = 1'b1;
      t   = -1;
      for (int k = 0; k < 40; k++) begin
         step();
         exp_v = exp_out(t, {ZB, ZB, ZB, 8'h3F}, -1);
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_mid_post t=%0d got=%h exp=%h", t, obs, exp_v);
         end
      end
   endtask

   task automatic test_leading_zero();
      while (t < 95) begin
         wr_en  = 1'b0;
         commit = 1'b0;
         case (t + 1)
            41: begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = 5'h04; end
            45: commit = 1'b1;
            default: ;
         endcase
         step();
         exp_v = (t < 64) ? exp_out(t, {ZB, ZB, ZB, 8'h3F}, -1)
                          : exp_out(t, {ZB, ZB, 8'h66, 8'h3F}, 64);
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL leading_zero t=%0d got=%h exp=%h", t, obs, exp_v);
         end
      end
      wr_en  = 1'b0;
      commit = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_commit_deferred();
      test_write_on_copy();
      test_ignored_addr_merge();
      test_reset_mid_slot();
      test_leading_zero();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
